serial_tx_scheduler: RTL
========================

Name: serial_tx_scheduler

Overview:
Shares one SerialTx byte transmitter among REQUESTERS independent byte sources, for example the CPU UART register path and a debug/monitor channel. Each requester has a one-byte holding register. A round-robin FSM picks a pending byte, issues a single-cycle dataLoad pulse to SerialTx when it is ready, and tracks the frame until ready returns. It then reports completion to the owning requester and retries loads that SerialTx never took.

Parameters:
REQUESTERS, 2, number of requesters (≥2).
LOAD_TIMEOUT, 4, WAIT_BUSY cycles with txReady=1 before a load is abandoned and retried (≥2).
TIMEOUT_BITS, 3, width of the timeout counter; must hold LOAD_TIMEOUT-1.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
reqValid  in  REQUESTERS  requester i has a byte on reqData
reqData  in  8*REQUESTERS  byte for requester i at [8i+7:8i]
reqAccept  out  REQUESTERS  1-cycle pulse: byte i captured into holding register
reqDone  out  REQUESTERS  1-cycle pulse: byte i fully transmitted (stop bit done)
grant  out  REQUESTERS  one-hot owner of current transfer; 0 in IDLE
busy  out  1  any holding register full or FSM not IDLE
txData  out  8  to SerialTx data
txLoad  out  1  to SerialTx dataLoad
txReady  in  1  from SerialTx ready

Behaviour:
- Reset (async, any state): FSM=IDLE; all holding registers empty. reqAccept, reqDone, grant, txLoad, timeout counter = 0. txData=0. busy=0. lastGrant=REQUESTERS-1, so requester 0 wins first. Bytes in flight are dropped with no reqDone.
- All outputs are registered.
- Capture: at an edge where reqValid[i]=1 and full[i]=0:
  - hold[i] <= reqData slice, full[i] <= 1, reqAccept[i]=1 for the next cycle.
  - A requester must change or drop reqValid in the cycle it sees reqAccept.
  - full[i] stays 1 until reqDone[i], so there is no double capture.
- SerialTx contract: the transmitter loads only on a dataLoad assertion while ready=1, and ignores a dataLoad held high. The scheduler therefore:
  - asserts txLoad for exactly one cycle per attempt;
  - keeps txLoad low ≥1 cycle between pulses;
  - never asserts txLoad while txReady=0.
- FSM states:
  - IDLE:
    - If txReady=1 and any full[i]=1, select g = first full index searching lastGrant+1, lastGrant+2, … mod REQUESTERS.
    - Next edge: txData<=hold[g], txLoad<=1, grant<=onehot(g), counter<=0, ->WAIT_BUSY.
    - Otherwise stay.
  - WAIT_BUSY:
    - txLoad<=0 at the first edge.
    - txReady=0 -> WAIT_DONE.
    - txReady=1 with counter=LOAD_TIMEOUT-1 -> IDLE, grant<=0. Holding is kept and lastGrant is unchanged, so the same requester is retried.
    - Otherwise counter+1.
  - WAIT_DONE:
    - On txReady=1: reqDone[g]=1 for one cycle, full[g]<=0, lastGrant<=g, grant<=0, ->IDLE.
- Latency: reqValid seen at edge e -> reqAccept and full set at e -> txLoad high from e+1 (IDLE, txReady=1). The next frame's txLoad comes ≥1 cycle after reqDone.
- Simultaneous events:
  - A capture into hold[j] during another requester's transfer is allowed.
  - A capture into hold[g] is possible only after full[g] clears, so reqValid[g] sampled in the reqDone cycle is captured at the following edge.
  - Several pending requests: strict round-robin, no starvation.
- txData holds its value after the pulse until the next load (don't-care to SerialTx).
- Reset mid-frame: SerialTx may still be busy. After reset the FSM waits in IDLE for txReady=1 before any load.

Test Plan:
1. Assert reset mid-simulation with reqValid=11 -> txLoad, grant, reqAccept, reqDone, busy all 0 during and after reset; no capture while reset is high.
2. Real SerialTx (counterBits=2, delay=3); req0 sends 0x65 once -> one reqAccept[0] pulse; txLoad high exactly 1 cycle with txData=0x65 and grant=01. serialOut follows 0,1,0,1,0,0,1,1,0,1, 3 cycles per bit. reqDone[0] pulses once, 1 cycle after txReady returns to 1; busy=0 afterwards.
3. Both requesters valid from the same cycle, req0=0xA0 and req1=0x5A, each refilling with a new byte on every accept for 4 frames -> grant sequence 01,10,01,10. Byte order on serialOut matches. Every reqDone pairs with its earlier reqAccept.
4. Back-to-back frames -> txLoad never high while txReady=0. txLoad is low ≥1 cycle between pulses. No frame is lost (SerialTx would ignore a held-high load).
5. Stub txReady tied to 1, req1=0x3C -> txLoad pulses with period LOAD_TIMEOUT+1=5 cycles, txData=0x3C each time, grant 10 on each attempt. No reqDone; busy stays 1.
6. Assert reset during the data bits of a req0 frame with req1 pending -> no reqDone. After reset, new req1=0x11 is accepted, but txLoad waits until txReady=1, then 0x11 is sent correctly.

Source files
------------

// File: rtl/serial_tx_scheduler_if.sv
// rtl/serial_tx_scheduler_if.sv - requester and SerialTx signals of the transmit scheduler
interface serial_tx_scheduler_if #(
  parameter int REQUESTERS = 2
);
  logic [REQUESTERS-1:0]   reqValid;
  logic [8*REQUESTERS-1:0] reqData;
  logic [REQUESTERS-1:0]   reqAccept;
  logic [REQUESTERS-1:0]   reqDone;
  logic [REQUESTERS-1:0]   grant;
  logic                    busy;
  logic [7:0]              txData;
  logic                    txLoad;
  logic                    txReady;

  modport master (
    output reqValid, reqData, txReady,
    input  reqAccept, reqDone, grant, busy, txData, txLoad
  );

  modport slave (
    input  reqValid, reqData, txReady,
    output reqAccept, reqDone, grant, busy, txData, txLoad
  );
endinterface

// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - round-robin sharing of one SerialTx among byte requesters
module serial_tx_scheduler #(
  parameter int REQUESTERS   = 2,
  parameter int LOAD_TIMEOUT = 4,
  parameter int TIMEOUT_BITS = 3
) (
  input logic clk,
  input logic reset,
  serial_tx_scheduler_if.slave bus
);
  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [REQUESTERS-1:0] ONE = REQUESTERS'(1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state;
  logic [7:0]              hold [REQUESTERS];
  logic [REQUESTERS-1:0]   full;
  logic [REQUESTERS-1:0]   full_nxt;
  logic [REQUESTERS-1:0]   capture;
  logic [REQUESTERS-1:0]   release_hold;
  logic [IW-1:0]           last_grant;
  logic [IW-1:0]           cur;
  logic [IW-1:0]           pick;
  logic                    any_full;
  logic [TIMEOUT_BITS-1:0] cnt;

  // A slot is released on the completing edge and only refilled on the next one.
  always_comb begin
    release_hold = '0;
    if (state == WAIT_DONE && bus.txReady) begin
      release_hold[cur] = 1'b1;
    end
    capture  = bus.reqValid & ~full;
    full_nxt = (full & ~release_hold) | capture;
  end

  // Walk from the farthest candidate back so the first one after last_grant wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = last_grant;
    any_full = 1'b0;
    for (int k = REQUESTERS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % REQUESTERS;
      if (full[idx]) begin
        pick     = IW'(idx);
        any_full = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      full          <= '0;
      last_grant    <= IW'(REQUESTERS - 1);
      cur           <= '0;
      cnt           <= '0;
      bus.reqAccept <= '0;
      bus.reqDone   <= '0;
      bus.grant     <= '0;
      bus.busy      <= 1'b0;
      bus.txData    <= '0;
      bus.txLoad    <= 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      full          <= full_nxt;
      bus.busy      <= |full_nxt;
      bus.reqAccept <= capture;
      bus.reqDone   <= '0;
      for (int i = 0; i < REQUESTERS; i++) begin
        if (capture[i]) begin
          hold[i] <= bus.reqData[8*i +: 8];
        end
      end
      case (state)
        IDLE: begin
          if (bus.txReady && any_full) begin
            cur        <= pick;
            bus.txData <= hold[pick];
            bus.txLoad <= 1'b1;
            bus.grant  <= ONE << pick;
            cnt        <= '0;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          bus.txLoad <= 1'b0;
          if (!bus.txReady) begin
            state <= WAIT_DONE;
          end else if (cnt == TIMEOUT_BITS'(LOAD_TIMEOUT - 1)) begin
            // Load never taken: keep the byte and last_grant so the same owner retries.
            bus.grant <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.txReady) begin
            bus.reqDone <= release_hold;
            last_grant  <= cur;
            bus.grant   <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
